// File: rtl/ch7301_i2c_master.sv
`default_nettype none
//============================================================================
// Module   : ch7301_i2c_master
// Purpose  : Single-master I2C initiator that programs the CH7301C video
//            encoder with single-register byte writes. Each write is
//            START, {DEV_ADDR,0}, register, data (each frame followed by an
//            ACK slot), then STOP. SCL is push-pull because this block is the
//            only master on the bus. SDA is open-drain (driven low or
//            released).
// Ports    : clk, rst (async, active high)
//            cmd_valid/cmd_ready      - command handshake
//            cmd_rd, cmd_reg, cmd_data - command fields, latched on accept
//            rd_data                  - byte returned by a read
//            busy, done, ack_err      - transaction status
//            I2C_SCL_video            - I2C clock (push-pull)
//            I2C_SDA_video            - I2C data (0 or Z only)
// Options  : I2C_READ_EN - when defined, cmd_rd=1 runs a register read
//            (START, addr+W, reg, repeated START, addr+R, 8 data bits,
//            master NACK, STOP). When undefined cmd_rd is ignored and
//            rd_data is tied to 8'h00.
// Revision : 1.0 - initial release
//============================================================================
module ch7301_i2c_master #(
    parameter logic [6:0] DEV_ADDR = 7'h76,
    parameter int         CLK_DIV  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       I2C_SCL_video,
    inout  wire        I2C_SDA_video
);

    localparam logic [9:0] c_QEND   = 10'(CLK_DIV - 1);
    localparam logic [7:0] c_ADDR_W = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BIT    = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4,
        S_RSTART = 3'd5
    } state_t;

    state_t     r_state;
    logic [9:0] r_qcnt;       // clk count within the current quarter
    logic [1:0] r_phase;      // quarter index within the current slot/condition
    logic [3:0] r_bit_cnt;    // slot within the frame, 8 = ACK slot
    logic [1:0] r_byte_idx;   // frame index within the transaction
    logic [6:0] r_shift;      // bits still to send after the current MSB
    logic [7:0] r_reg;
    logic [7:0] r_data;
    logic       r_scl;
    logic       r_sda_oe;     // 1 = pull SDA low
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic       r_ack;        // SDA level sampled in the latest ACK slot

    logic       w_qend;
    logic       w_timed;
    logic       w_sda_in;
    logic [7:0] w_next;
    logic       w_rx_frame;   // current frame is the byte read from the slave
    logic       w_final_tx;   // current frame is the last one sent by the master

`ifdef I2C_READ_EN
    localparam logic [7:0] c_ADDR_R = {DEV_ADDR, 1'b1};
    logic       r_rd;
    logic [7:0] r_rx;
    logic [7:0] r_rd_data;

    assign w_rx_frame = (r_byte_idx == 2'd3);
    assign w_final_tx = !r_rd && (r_byte_idx == 2'd2);
    assign rd_data    = r_rd_data;
`else
    logic w_unused_rd;

    assign w_unused_rd = cmd_rd;
    assign w_rx_frame  = 1'b0;
    assign w_final_tx  = (r_byte_idx == 2'd2);
    assign rd_data     = 8'h00;
`endif

    assign w_qend    = (r_qcnt == c_QEND);
    assign w_timed   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_sda_in  = I2C_SDA_video;
    // Frame that follows the current one on a plain write.
    assign w_next    = (r_byte_idx == 2'd0) ? r_reg : r_data;

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = r_busy;
    assign done          = r_done;
    assign ack_err       = r_ack_err;
    assign I2C_SCL_video = r_scl;
    assign I2C_SDA_video = r_sda_oe ? 1'b0 : 1'bz;

    // Outputs are registered: every assignment to r_scl / r_sda_oe below is
    // made on the edge that opens the quarter it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_qcnt     <= 10'd0;
            r_phase    <= 2'd0;
            r_bit_cnt  <= 4'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 7'd0;
            r_reg      <= 8'h00;
            r_data     <= 8'h00;
            r_scl      <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_ack      <= 1'b0;
`ifdef I2C_READ_EN
            r_rd       <= 1'b0;
            r_rx       <= 8'h00;
            r_rd_data  <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_timed && !w_qend) begin
                r_qcnt <= r_qcnt + 10'd1;
            end else begin
                r_qcnt <= 10'd0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_reg     <= cmd_reg;
                        r_data    <= cmd_data;
`ifdef I2C_READ_EN
                        r_rd      <= cmd_rd;
`endif
                        r_busy    <= 1'b1;
                        r_ack_err <= 1'b0;
                        r_state   <= S_START;
                        r_phase   <= 2'd0;
                        r_scl     <= 1'b1;
                        r_sda_oe  <= 1'b1;   // START: SDA falls with SCL high
                    end
                end

                S_START: begin
                    if (w_qend) begin
                        if (r_phase == 2'd0) begin
                            r_phase <= 2'd1;
                        end else begin
                            r_state    <= S_BIT;
                            r_phase    <= 2'd0;
                            r_bit_cnt  <= 4'd0;
                            r_byte_idx <= 2'd0;
                            r_shift    <= c_ADDR_W[6:0];
                            r_scl      <= 1'b0;
                            r_sda_oe   <= ~c_ADDR_W[7];
                        end
                    end
                end

                S_BIT: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd0: r_phase <= 2'd1;
                            2'd1: begin
                                r_phase <= 2'd2;
                                r_scl   <= 1'b1;
                            end
                            2'd2: begin
                                // Last clk of the first high quarter.
                                r_phase <= 2'd3;
                                if (r_bit_cnt == 4'd8) begin
                                    r_ack <= w_sda_in;
                                end
`ifdef I2C_READ_EN
                                else begin
                                    r_rx <= {r_rx[6:0], w_sda_in};
                                end
`endif
                            end
                            default: begin
                                // Slot boundary: SCL falls, SDA takes its
                                // value for the next slot on the same edge.
                                r_phase <= 2'd0;
                                r_scl   <= 1'b0;
                                if (r_bit_cnt != 4'd8) begin
                                    r_bit_cnt <= r_bit_cnt + 4'd1;
                                    r_shift   <= {r_shift[5:0], 1'b0};
                                    r_sda_oe  <= (r_bit_cnt == 4'd7) ? 1'b0 : ~r_shift[6];
`ifdef I2C_READ_EN
                                    if (w_rx_frame) begin
                                        r_sda_oe <= 1'b0;   // slave owns SDA
                                    end
`endif
                                end else if (w_rx_frame || r_ack || w_final_tx) begin
                                    // NACK after a master frame aborts the
                                    // rest; the read byte ends with the
                                    // master's own NACK and is not an error.
                                    r_state  <= S_STOP;
                                    r_sda_oe <= 1'b1;
                                    if (!w_rx_frame && r_ack) begin
                                        r_ack_err <= 1'b1;
                                    end
                                end
`ifdef I2C_READ_EN
                                else if (r_rd && (r_byte_idx == 2'd1)) begin
                                    r_state  <= S_RSTART;
                                    r_sda_oe <= 1'b0;
                                end else if (r_byte_idx == 2'd2) begin
                                    r_byte_idx <= 2'd3;
                                    r_bit_cnt  <= 4'd0;
                                    r_sda_oe   <= 1'b0;
                                end
`endif
                                else begin
                                    r_byte_idx <= r_byte_idx + 2'd1;
                                    r_bit_cnt  <= 4'd0;
                                    r_shift    <= w_next[6:0];
                                    r_sda_oe   <= ~w_next[7];
                                end
                            end
                        endcase
                    end
                end

`ifdef I2C_READ_EN
                S_RSTART: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd0: begin
                                r_phase <= 2'd1;
                                r_scl   <= 1'b1;
                            end
                            2'd1: begin
                                r_phase  <= 2'd2;
                                r_sda_oe <= 1'b1;   // repeated START edge
                            end
                            default: begin
                                r_state    <= S_BIT;
                                r_phase    <= 2'd0;
                                r_bit_cnt  <= 4'd0;
                                r_byte_idx <= 2'd2;
                                r_shift    <= c_ADDR_R[6:0];
                                r_scl      <= 1'b0;
                                r_sda_oe   <= ~c_ADDR_R[7];
                            end
                        endcase
                    end
                end
`endif

                S_STOP: begin
                    if (w_qend) begin
                        case (r_phase)
                            2'd0: begin
                                r_phase <= 2'd1;
                                r_scl   <= 1'b1;
                            end
                            2'd1: begin
                                r_phase  <= 2'd2;
                                r_sda_oe <= 1'b0;   // STOP: SDA rises with SCL high
                            end
                            default: begin
                                r_phase <= 2'd0;
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
`ifdef I2C_READ_EN
                                if (r_rd && !r_ack_err) begin
                                    r_rd_data <= r_rx;
                                end
`endif
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ch7301_i2c_master.sv
`default_nettype none
//============================================================================
// Module   : tb_ch7301_i2c_master
// Purpose  : Self-checking bench for ch7301_i2c_master. A behavioural I2C
//            responder acknowledges (or not) and, for reads, returns a byte.
//            A bus monitor decodes START/STOP conditions and the bit seen on
//            every SCL rise; a frame-level model predicts bits, latency and
//            status for each command.
// Options  : I2C_READ_EN - also exercises register reads.
// Revision : 1.0 - initial release
//============================================================================
module tb_ch7301_i2c_master;

    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] DEV_ADDR = 7'h76;
`ifdef I2C_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_rd;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    wire        cmd_ready;
    wire [7:0]  rd_data;
    wire        busy;
    wire        done;
    wire        ack_err;
    wire        scl;
    wire        sda;
    logic       resp_low;

    pullup (sda);
    assign sda = resp_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ch7301_i2c_master #(
        .DEV_ADDR (DEV_ADDR),
        .CLK_DIV  (CLK_DIV)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rd        (cmd_rd),
        .cmd_reg       (cmd_reg),
        .cmd_data      (cmd_data),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .ack_err       (ack_err),
        .I2C_SCL_video (scl),
        .I2C_SDA_video (sda)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    bit         prev_scl = 1'b1;
    bit         prev_sda = 1'b1;
    int         fall_cnt = 0;
    int         seg      = 0;
    bit         resp_ack = 1'b0;
    logic [7:0] resp_byte = 8'h00;
    bit         obs_bits[$];
    int         rise_t[$];
    int         n_start = 0;
    int         n_stop  = 0;
    logic [7:0] exp_rd  = 8'h00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample the bus on the falling clk edge, decode it and
    // update the responder's SDA pull-down.
    task automatic tick();
        bit s_scl;
        bit s_sda;
        int slot;
        int f;
        int pos;
        @(negedge clk);
        cyc++;
        s_scl = (scl === 1'b1);
        s_sda = (sda !== 1'b0);
        if (prev_scl && s_scl && prev_sda && !s_sda) begin
            n_start++;
            seg      = n_start - 1;
            fall_cnt = 0;
            // The SCL rise that preceded a repeated START is not a data bit.
            if (obs_bits.size() > 0) begin
                void'(obs_bits.pop_back());
                void'(rise_t.pop_back());
            end
        end
        if (prev_scl && s_scl && !prev_sda && s_sda) begin
            n_stop++;
            if (obs_bits.size() > 0) begin
                void'(obs_bits.pop_back());
                void'(rise_t.pop_back());
            end
        end
        if (!prev_scl && s_scl) begin
            obs_bits.push_back(s_sda);
            rise_t.push_back(cyc);
        end
        if (prev_scl && !s_scl) begin
            fall_cnt++;
            slot     = fall_cnt - 1;
            f        = slot / 9;
            pos      = slot % 9;
            resp_low = 1'b0;
            if (resp_ack) begin
                if (seg == 0 && f < 3 && pos == 8) resp_low = 1'b1;
                if (seg == 1 && f == 0 && pos == 8) resp_low = 1'b1;
                if (seg == 1 && f == 1 && pos < 8) resp_low = ~resp_byte[7 - pos];
            end
        end
        prev_scl = s_scl;
        prev_sda = s_sda;
    endtask

    // Frame-level prediction of one command.
    function automatic void model(input logic [7:0] r, input logic [7:0] d, input logic [7:0] rx,
                                  input bit rd, input bit ack,
                                  output int q, output int nb, output logic [63:0] bits,
                                  output int nst, output bit err);
        bit is_rd;
        is_rd = rd && READ_EN;
        err   = !ack;
        nst   = 1;
        bits  = 64'd0;
        bits  = {bits[54:0], {DEV_ADDR, 1'b0}, !ack};
        nb    = 9;
        q     = 2 + 36;
        if (ack) begin
            bits = {bits[54:0], r, 1'b0};
            nb   = nb + 9;
            q    = q + 36;
            if (is_rd) begin
                nst  = 2;
                bits = {bits[54:0], {DEV_ADDR, 1'b1}, 1'b0};
                bits = {bits[54:0], rx, 1'b1};
                nb   = nb + 18;
                q    = q + 3 + 72;
            end else begin
                bits = {bits[54:0], d, 1'b0};
                nb   = nb + 9;
                q    = q + 36;
            end
        end
        q = q + 3;
    endfunction

    task automatic run_txn(input logic [7:0] r, input logic [7:0] d, input bit rd, input bit ack,
                           input logic [7:0] rx, input bit junk, input bit chain,
                           input logic [7:0] nr, input logic [7:0] nd, input bit nrd);
        int          q_exp;
        int          nb_exp;
        int          nst_exp;
        int          rel;
        int          bad_rdy;
        int          bad_int;
        bit          err_exp;
        logic [63:0] bits_exp;
        logic [63:0] bits_obs;

        model(r, d, rx, rd, ack, q_exp, nb_exp, bits_exp, nst_exp, err_exp);
        resp_ack  = ack;
        resp_byte = rx;
        obs_bits.delete();
        rise_t.delete();
        n_start   = 0;
        n_stop    = 0;
        seg       = 0;
        fall_cnt  = 0;

        chk("accept_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_reg   = r;
        cmd_data  = d;
        cmd_rd    = rd;
        tick();
        rel = 1;
        chk("busy_after_accept", 64'({busy, cmd_ready, ack_err}), 64'(3'b100));

        bad_rdy = 0;
        while (done !== 1'b1 && rel < 2000) begin
            if (cmd_ready !== 1'b0) bad_rdy++;
            if (!chain) begin
                if (junk && rel < 150) begin
                    cmd_valid = 1'($urandom_range(0, 1));
                    cmd_reg   = 8'($urandom);
                    cmd_data  = 8'($urandom);
                    cmd_rd    = 1'($urandom_range(0, 1));
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            tick();
            rel++;
        end

        if (rd && READ_EN && ack) exp_rd = rx;
        chk("done_latency", 64'(rel), 64'(q_exp * CLK_DIV + 1));
        chk("done_flags", 64'({busy, cmd_ready, ack_err}), 64'({1'b1, 1'b0, err_exp}));
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
        if (chain) begin
            cmd_reg  = nr;
            cmd_data = nd;
            cmd_rd   = nrd;
        end
        tick();
        chk("idle_after_done", 64'({done, busy, cmd_ready}), 64'(3'b001));
        chk("ready_while_busy", 64'(bad_rdy), 64'd0);

        bits_obs = 64'd0;
        foreach (obs_bits[i]) bits_obs = {bits_obs[62:0], obs_bits[i]};
        chk("bit_count", 64'(obs_bits.size()), 64'(nb_exp));
        chk("bus_bits", bits_obs, bits_exp);
        chk("start_count", 64'(n_start), 64'(nst_exp));
        chk("stop_count", 64'(n_stop), 64'd1);
        bad_int = 0;
        for (int i = 1; i < rise_t.size(); i++) begin
            if (rise_t[i] - rise_t[i - 1] != 4 * CLK_DIV) bad_int++;
        end
        chk("scl_period", 64'(bad_int), 64'((nst_exp == 2) ? 1 : 0));
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rd    = 1'b0;
        cmd_reg   = 8'h00;
        cmd_data  = 8'h00;
        resp_low  = 1'b0;
        repeat (3) tick();
        chk("reset_bus", 64'({scl, sda !== 1'b0}), 64'(2'b11));
        chk("reset_status", 64'({cmd_ready, busy, done, ack_err}), 64'(4'b1000));
        chk("reset_rd_data", 64'(rd_data), 64'h00);
        rst = 1'b0;
        repeat (2) tick();

        // Basic write and a missing device.
        run_txn(8'h49, 8'hC0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_txn(8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Back-to-back with cmd_valid held high.
        run_txn(8'h21, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h1C, 8'h8F, 1'b0);
        run_txn(8'h1C, 8'h8F, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

`ifdef I2C_READ_EN
        run_txn(8'h4A, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_txn(8'h4B, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
`endif

        // Reset in the middle of the register frame.
        obs_bits.delete();
        rise_t.delete();
        n_start   = 0;
        n_stop    = 0;
        fall_cnt  = 0;
        seg       = 0;
        resp_ack  = 1'b1;
        cmd_valid = 1'b1;
        cmd_rd    = 1'b0;
        cmd_reg   = 8'h66;
        cmd_data  = 8'h99;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (obs_bits.size() < 12 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("reach_reg_frame", 64'(obs_bits.size()), 64'd12);
        #1 rst = 1'b1;
        resp_low = 1'b0;
        #1;
        chk("rst_async", 64'({scl, sda !== 1'b0, busy, cmd_ready, done}), 64'(5'b11010));
        tick();
        rst = 1'b0;
        tick();
        run_txn(8'h66, 8'h99, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Randomized commands.
        for (int k = 0; k < 8; k++) begin
            run_txn(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'b0, 8'h00, 8'h00, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
